// File: rtl/img_pkg.sv
// Shared constants for the image-pipeline sequencer: default geometry, operation
// indices, sequencer state encoding and mask helpers.
package img_pkg;

   localparam int IMG_ROW_W = 6;
   localparam int IMG_COL_W = 6;
   localparam int IMG_PIX_W = 24;

   localparam int OP_MIRROR = 0;
   localparam int OP_GRAY   = 1;
   localparam int OP_FILTER = 2;
   localparam int N_OPS     = 3;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LAUNCH = 3'd1;
   localparam state_t ST_RUN    = 3'd2;
   localparam state_t ST_NEXT   = 3'd3;
   localparam state_t ST_FIN    = 3'd4;

   // Index of the lowest requested op; only meaningful when the mask is non-zero.
   function automatic logic [1:0] lowest_op(input logic [2:0] mask);
      if (mask[OP_MIRROR])    return 2'(OP_MIRROR);
      else if (mask[OP_GRAY]) return 2'(OP_GRAY);
      else                    return 2'(OP_FILTER);
   endfunction

   function automatic logic [2:0] ops_above(input logic [2:0] mask, input logic [1:0] cur);
      case (cur)
         2'd0:    return mask & 3'b110;
         2'd1:    return mask & 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/img_port_mux.sv
// Combinational 3:1 grant mux for the shared image-memory port; only the granted
// engine's write enable passes, otherwise the held address/pixel is presented.
module img_port_mux
   import img_pkg::*;
#(
   parameter int ROW_W = IMG_ROW_W,
   parameter int COL_W = IMG_COL_W,
   parameter int PIX_W = IMG_PIX_W
) (
   input  logic [1:0]         sel,
   input  logic               grant,
   input  logic [3*ROW_W-1:0] eng_row,
   input  logic [3*COL_W-1:0] eng_col,
   input  logic [2:0]         eng_we,
   input  logic [3*PIX_W-1:0] eng_pix,
   input  logic [ROW_W-1:0]   hold_row,
   input  logic [COL_W-1:0]   hold_col,
   input  logic [PIX_W-1:0]   hold_pix,
   output logic [ROW_W-1:0]   mem_row,
   output logic [COL_W-1:0]   mem_col,
   output logic               mem_we,
   output logic [PIX_W-1:0]   mem_pix
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path infers a latch.
      mem_row = hold_row;
      mem_col = hold_col;
      mem_pix = hold_pix;
      mem_we  = 1'b0;
      for (int i = 0; i < N_OPS; i++) begin
         if (grant && sel == 2'(i)) begin
            mem_row = eng_row[i*ROW_W +: ROW_W];
            mem_col = eng_col[i*COL_W +: COL_W];
            mem_pix = eng_pix[i*PIX_W +: PIX_W];
            mem_we  = eng_we[i];
         end
      end
   end

endmodule

// File: rtl/img_op_sequencer.sv
// Runs the selected ops in order mirror -> gray -> filter, one engine at a time, owning
// the shared memory port. Optional per-op watchdog enabled by defining IMG_WDOG_EN.
module img_op_sequencer
   import img_pkg::*;
#(
   parameter int ROW_W = IMG_ROW_W,
   parameter int COL_W = IMG_COL_W,
   parameter int PIX_W = IMG_PIX_W
`ifdef IMG_WDOG_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 65536
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2:0]         op_mask,
   output logic [2:0]         eng_start,
   input  logic [2:0]         eng_done,
   input  logic [3*ROW_W-1:0] eng_row,
   input  logic [3*COL_W-1:0] eng_col,
   input  logic [2:0]         eng_we,
   input  logic [3*PIX_W-1:0] eng_pix,
   output logic [ROW_W-1:0]   mem_row,
   output logic [COL_W-1:0]   mem_col,
   output logic               mem_we,
   output logic [PIX_W-1:0]   mem_pix,
   output logic               busy,
   output logic               mirror_done,
   output logic               gray_done,
   output logic               filter_done,
   output logic               seq_done,
   output logic               wdog_err
);

   state_t             state, state_nxt;
   logic [2:0]         mask_q;
   logic [1:0]         cur;
   logic               armed;
   logic [2:0]         flags;
   logic [ROW_W-1:0]   row_q;
   logic [COL_W-1:0]   col_q;
   logic [PIX_W-1:0]   pix_q;
   logic               done_cur;
   logic               op_complete;
   logic               timeout;

   assign done_cur    = eng_done[cur];
   assign op_complete = armed && done_cur;

`ifdef IMG_WDOG_EN
   logic [16:0] wdog_cnt;
   logic        wdog_q;

   assign timeout  = (state == ST_RUN) && (wdog_cnt == 17'(TIMEOUT_CYC));
   assign wdog_err = wdog_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt <= '0;
         wdog_q   <= 1'b0;
      end else begin
         if (state == ST_IDLE && start) wdog_q <= 1'b0;
         if (state == ST_LAUNCH) wdog_cnt <= '0;
         else if (state == ST_RUN) wdog_cnt <= wdog_cnt + 17'd1;
         if (timeout && !op_complete) wdog_q <= 1'b1;
      end
   end
`else
   assign timeout  = 1'b0;
   assign wdog_err = 1'b0;
`endif

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = (op_mask == 3'b000) ? ST_FIN : ST_LAUNCH;
         ST_LAUNCH: state_nxt = ST_RUN;
         ST_RUN: begin
            if (op_complete)  state_nxt = ST_NEXT;
            else if (timeout) state_nxt = ST_FIN;
         end
         ST_NEXT:   state_nxt = (ops_above(mask_q, cur) != 3'b000) ? ST_LAUNCH : ST_FIN;
         ST_FIN:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Armed guards against a done level left high by the engine's previous run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
         cur    <= '0;
         armed  <= 1'b0;
         flags  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               mask_q <= op_mask;
               flags  <= '0;
               cur    <= lowest_op(op_mask);
            end
            ST_LAUNCH: armed <= 1'b0;
            ST_RUN: begin
               if (!done_cur)   armed      <= 1'b1;
               if (op_complete) flags[cur] <= 1'b1;
            end
            ST_NEXT: cur <= lowest_op(ops_above(mask_q, cur));
            default: ;
         endcase
      end
   end

   // Last granted address/pixel, presented while no engine owns the port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q <= '0;
         col_q <= '0;
         pix_q <= '0;
      end else if (state == ST_RUN) begin
         row_q <= mem_row;
         col_q <= mem_col;
         pix_q <= mem_pix;
      end
   end

   always_comb begin
      eng_start = 3'b000;
      if (state == ST_LAUNCH) eng_start[cur] = 1'b1;
   end

   assign busy        = (state != ST_IDLE);
   assign seq_done    = (state == ST_FIN);
   assign mirror_done = flags[OP_MIRROR];
   assign gray_done   = flags[OP_GRAY];
   assign filter_done = flags[OP_FILTER];

   img_port_mux #(
      .ROW_W (ROW_W),
      .COL_W (COL_W),
      .PIX_W (PIX_W)
   ) u_port_mux (
      .sel      (cur),
      .grant    (state == ST_RUN),
      .eng_row  (eng_row),
      .eng_col  (eng_col),
      .eng_we   (eng_we),
      .eng_pix  (eng_pix),
      .hold_row (row_q),
      .hold_col (col_q),
      .hold_pix (pix_q),
      .mem_row  (mem_row),
      .mem_col  (mem_col),
      .mem_we   (mem_we),
      .mem_pix  (mem_pix)
   );

endmodule

// File: tb/tb_img_op_sequencer.sv
// Directed bench for img_op_sequencer; watchdog scenario changes when IMG_WDOG_EN is defined.
module tb_img_op_sequencer;
   import img_pkg::*;

   localparam int RW = IMG_ROW_W;
   localparam int CW = IMG_COL_W;
   localparam int PW = IMG_PIX_W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op_mask = 3'b000;
   logic [2:0]    eng_start;
   logic [2:0]    eng_done;
   logic [3*RW-1:0] eng_row;
   logic [3*CW-1:0] eng_col;
   logic [2:0]    eng_we;
   logic [3*PW-1:0] eng_pix;
   logic [RW-1:0] mem_row;
   logic [CW-1:0] mem_col;
   logic          mem_we;
   logic [PW-1:0] mem_pix;
   logic          busy, mirror_done, gray_done, filter_done, seq_done, wdog_err;

   logic [RW-1:0] e_row [3];
   logic [CW-1:0] e_col [3];
   logic [PW-1:0] e_pix [3];
   logic [2:0]    e_we = 3'b000;
   logic          auto_mode = 1'b1;
   logic [2:0]    man_done = 3'b000;
   logic [2:0]    mdl_done = 3'b000;
   int            mdl_cnt [3] = '{0, 0, 0};
   int            lat [3] = '{10, 20, 30};

   int errors = 0;
   int checks = 0;

   logic [2:0] log_q [$];
   int         done_cyc, done_cnt, mflag_cyc, fstart_cyc;
   logic       we_seen, first_busy;

   assign eng_row  = {e_row[2], e_row[1], e_row[0]};
   assign eng_col  = {e_col[2], e_col[1], e_col[0]};
   assign eng_pix  = {e_pix[2], e_pix[1], e_pix[0]};
   assign eng_we   = e_we;
   assign eng_done = auto_mode ? mdl_done : man_done;

   logic [45:0] all_outs;
   assign all_outs = {eng_start, mem_row, mem_col, mem_we, mem_pix, busy,
                      mirror_done, gray_done, filter_done, seq_done, wdog_err};

   always #5 clk = ~clk;

   // Engine model: done drops on launch and rises lat[i] cycles later, then stays high.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (eng_start[i]) begin
            mdl_cnt[i]  <= lat[i];
            mdl_done[i] <= 1'b0;
         end else if (mdl_cnt[i] > 0) begin
            mdl_cnt[i] <= mdl_cnt[i] - 1;
            if (mdl_cnt[i] == 1) mdl_done[i] <= 1'b1;
         end
      end
   end

`ifdef IMG_WDOG_EN
   img_op_sequencer #(.TIMEOUT_CYC(100)) dut (
`else
   img_op_sequencer dut (
`endif
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op_mask     (op_mask),
      .eng_start   (eng_start),
      .eng_done    (eng_done),
      .eng_row     (eng_row),
      .eng_col     (eng_col),
      .eng_we      (eng_we),
      .eng_pix     (eng_pix),
      .mem_row     (mem_row),
      .mem_col     (mem_col),
      .mem_we      (mem_we),
      .mem_pix     (mem_pix),
      .busy        (busy),
      .mirror_done (mirror_done),
      .gray_done   (gray_done),
      .filter_done (filter_done),
      .seq_done    (seq_done),
      .wdog_err    (wdog_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses start, then watches outputs each cycle until seq_done or the budget runs out.
   // Cycle 1 is the sample right after the edge that accepted start.
   task automatic run_seq(input logic [2:0] mask, input int budget);
      log_q.delete();
      done_cyc = -1; done_cnt = 0; mflag_cyc = -1; fstart_cyc = -1; we_seen = 1'b0;
      start = 1'b1;
      op_mask = mask;
      tick();
      start = 1'b0;
      op_mask = ~mask;
      first_busy = busy;
      for (int c = 1; c <= budget; c++) begin
         if (eng_start != 3'b000) begin
            log_q.push_back(eng_start);
            if (eng_start[OP_FILTER] && fstart_cyc < 0) fstart_cyc = c;
         end
         if (mirror_done && mflag_cyc < 0) mflag_cyc = c;
         if (mem_we) we_seen = 1'b1;
         if (seq_done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (done_cyc >= 0) break;
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         e_row[i] = '0;
         e_col[i] = '0;
         e_pix[i] = '0;
      end

      // Reset state
      #2;
      check("reset_outputs", 64'(all_outs), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("idle_outputs", 64'(all_outs), 64'd0);

      // Full run, all three ops
      run_seq(3'b111, 300);
      check("full_busy_at_launch", 64'(first_busy), 64'd1);
      check("full_launch_count", 64'(log_q.size()), 64'd3);
      check("full_launch_order", 64'({log_q[0], log_q[1], log_q[2]}), 64'(9'b001_010_100));
      check("full_flags", 64'({filter_done, gray_done, mirror_done}), 64'(3'b111));
      check("full_seq_done_count", 64'(done_cnt), 64'd1);
      tick();
      check("full_busy_after", 64'(busy), 64'd0);
      check("full_seq_done_pulse", 64'(seq_done), 64'd0);

      // Skip gray
      run_seq(3'b101, 300);
      check("skip_launch_order", 64'({log_q.size() == 2, log_q[0], log_q[1]}), 64'(7'b1_001_100));
      check("skip_flags", 64'({filter_done, gray_done, mirror_done}), 64'(3'b101));
      check("skip_next_to_launch", 64'(fstart_cyc - mflag_cyc), 64'd1);
      tick();

      // Empty mask
      run_seq(3'b000, 20);
      check("empty_seq_done_cycle", 64'(done_cyc), 64'd1);
      check("empty_no_launch", 64'(log_q.size()), 64'd0);
      check("empty_no_write", 64'(we_seen), 64'd0);
      check("empty_flags", 64'({filter_done, gray_done, mirror_done}), 64'd0);
      tick();
      check("empty_busy_after", 64'(busy), 64'd0);

      // Isolation: gray writes while mirror owns the port
      auto_mode = 1'b0;
      man_done  = 3'b000;
      e_row[0] = 6'd1; e_col[0] = 6'd2; e_pix[0] = 24'hAABBCC;
      e_row[1] = 6'd5; e_col[1] = 6'd7; e_pix[1] = 24'h555555;
      e_we = 3'b010;
      start = 1'b1; op_mask = 3'b001;
      tick();
      start = 1'b0; op_mask = 3'b110;
      check("iso_launch_pulse", 64'(eng_start), 64'(3'b001));
      check("iso_launch_no_write", 64'(mem_we), 64'd0);
      tick();
      check("iso_run_addr", 64'({mem_row, mem_col}), 64'({6'd1, 6'd2}));
      check("iso_run_gray_we_blocked", 64'(mem_we), 64'd0);
      e_we = 3'b011;
      #1;
      check("iso_run_mirror_we", 64'({mem_we, mem_pix}), 64'({1'b1, 24'hAABBCC}));
      e_we = 3'b010;
      #1;
      check("iso_run_mirror_we_low", 64'(mem_we), 64'd0);
      tick();
      e_we = 3'b011;
      man_done = 3'b001;
      tick();
      e_row[0] = 6'd9;
      #1;
      check("iso_next_no_write", 64'(mem_we), 64'd0);
      check("iso_next_hold_addr", 64'({mem_row, mem_col}), 64'({6'd1, 6'd2}));
      check("iso_mirror_flag", 64'(mirror_done), 64'd1);
      tick();
      check("iso_fin", 64'(seq_done), 64'd1);
      tick();
      check("iso_idle", 64'({busy, mem_we}), 64'd0);
      e_we = 3'b000;

      // Stale done and ignored restart
      man_done = 3'b001;
      start = 1'b1; op_mask = 3'b001;
      tick();
      start = 1'b0;
      check("stale_launch", 64'(eng_start), 64'(3'b001));
      tick();
      start = 1'b1; op_mask = 3'b111;
      tick();
      start = 1'b0;
      check("restart_ignored", 64'({eng_start, busy}), 64'({3'b000, 1'b1}));
      tick();
      tick();
      check("stale_held", 64'({mirror_done, seq_done, busy}), 64'(3'b001));
      man_done = 3'b000;
      tick();
      check("stale_low_not_done", 64'(mirror_done), 64'd0);
      man_done = 3'b001;
      tick();
      check("stale_done_after_low", 64'(mirror_done), 64'd1);
      tick();
      check("stale_fin", 64'({seq_done, gray_done, filter_done}), 64'(3'b100));
      tick();
      check("stale_idle", 64'(busy), 64'd0);

      // Asynchronous reset while gray is running
      man_done = 3'b000;
      e_we = 3'b010;
      start = 1'b1; op_mask = 3'b010;
      tick();
      start = 1'b0;
      tick();
      check("rst_run_granted", 64'({mem_we, mem_row}), 64'({1'b1, 6'd5}));
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_outputs", 64'(all_outs), 64'd0);
      #2;
      rst_n = 1'b1;
      e_we = 3'b000;
      tick();
      check("rst_idle_after", 64'(all_outs), 64'd0);

      // Stuck gray engine
      man_done = 3'b000;
`ifdef IMG_WDOG_EN
      run_seq(3'b010, 300);
      check("wdog_seq_done_cycle", 64'(done_cyc), 64'd103);
      check("wdog_flags", 64'({wdog_err, gray_done}), 64'(2'b10));
      tick();
      check("wdog_idle", 64'({busy, wdog_err}), 64'(2'b01));
`else
      run_seq(3'b010, 150);
      check("stuck_no_seq_done", 64'(done_cnt), 64'd0);
      check("stuck_busy_no_wdog", 64'({busy, wdog_err, gray_done}), 64'(3'b100));
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      check("stuck_reset_idle", 64'(all_outs), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
